// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   WIDTH_DEFAULT : default operand/sum width
//   state_e       : FSM state encoding (IDLE, RUN, DONE)
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder used for the per-bit arithmetic of serial_adder.
//   x, y : operand bits
//   cin  : carry in
//   cout : carry out
//   sum  : sum bit
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand set (a, b, cin) with a valid/ready
// handshake, adds it LSB first through one full-adder cell over WIDTH cycles,
// then presents sum, cout and signed overflow until the consumer takes them.
// Optional feature macro SERIAL_ADDER_SUB_EN adds an op_sub input that turns
// the operation into a - b (cout=1 then means no borrow, cin is ignored).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake
//   a, b, cin           : operands and carry in
//   op_sub              : subtract select (SERIAL_ADDER_SUB_EN builds only)
//   out_valid, out_ready: result handshake
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic               carry_msb;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic               accept;
    logic               bit_en;
    logic               run_end;
    logic               fa_sum;
    logic               fa_cout;

    // Operand conditioning: subtraction is a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff   = op_sub ? ~b : b;
    assign cin_eff = op_sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign accept  = in_valid && in_ready;
    // The cycle after the last bit is used to latch the result and enter DONE
    assign run_end = (state == RUN) && (cnt == CNT_W'(WIDTH));
    assign bit_en  = (state == RUN) && (cnt != CNT_W'(WIDTH));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (run_end)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    fa_cell u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    // Serial datapath: shift registers, carry, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= cin_eff;
            cnt   <= '0;
        end else if (bit_en) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            // Carry into the MSB, needed for signed overflow
            if (cnt == CNT_W'(WIDTH - 1)) begin
                carry_msb <= carry;
            end
        end else if (run_end) begin
            sum  <= sum_sh;
            cout <= carry;
            ovf  <= carry_msb ^ carry;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand set from IDLE, wait (bounded) for out_valid.
    // Leaves the result pending (out_ready low); lat = edges after the accepting edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         output int lat);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int ov_seen;
        int n_acc;
        int busy;
        int gaps_checked;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        op_sub    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", {21'd0, cout, ovf, 1'b0, sum}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 0 + 0 + 0, latency 9 edges
        do_op(8'h00, 8'h00, 1'b0, lat);
        check("zero_latency", 32'(lat), 32'd9);
        check("zero_sum", 32'(sum), 32'h00);
        check("zero_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        release_result();

        // 0xFF + 0x01: wraps, carry out, no signed overflow
        do_op(8'hFF, 8'h01, 1'b0, lat);
        check("ff01_latency", 32'(lat), 32'd9);
        check("ff01_sum", 32'(sum), 32'h00);
        check("ff01_cout", 32'(cout), 32'd1);
        check("ff01_ovf", 32'(ovf), 32'd0);
        release_result();

        // 0x80 + 0x80: carry out and signed overflow
        do_op(8'h80, 8'h80, 1'b0, lat);
        check("8080_sum", 32'(sum), 32'h00);
        check("8080_cout_ovf", {30'd0, cout, ovf}, 32'b11);
        release_result();

        // 0x7F + 0x00 + 1: signed overflow, no carry; then hold out_ready low
        do_op(8'h7F, 8'h00, 1'b1, lat);
        check("7f_sum", 32'(sum), 32'h80);
        check("7f_cout", 32'(cout), 32'd0);
        check("7f_ovf", 32'(ovf), 32'd1);
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_state", {28'd0, out_valid, in_ready, cout, ovf}, 32'b1001);
            check("hold_sum", 32'(sum), 32'h80);
        end
        in_valid = 1'b0;
        release_result();
        check("post_release_hs", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk);
        #1;
        check("idle_keeps_result", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h80});
        check("idle_keeps_ovf", 32'(ovf), 32'd1);

        // Reset at RUN bit 4: operation aborted, outputs cleared
        a        = 8'hFF;
        b        = 8'hFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrun_rst_hs", {30'd0, in_ready, out_valid}, 32'b10);
        check("midrun_rst_out", {22'd0, cout, ovf, sum}, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_seen++;
        end
        check("aborted_no_valid", 32'(ov_seen), 32'd0);
        check("aborted_out_zero", {22'd0, cout, ovf, sum}, 32'd0);
        do_op(8'h12, 8'h34, 1'b0, lat);
        check("after_rst_latency", 32'(lat), 32'd9);
        check("after_rst_sum", 32'(sum), 32'h46);
        check("after_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        release_result();

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction: cin ignored, cout=1 means no borrow
        op_sub = 1'b1;
        do_op(8'h05, 8'h07, 1'b1, lat);
        check("sub_5m7_sum", 32'(sum), 32'hFE);
        check("sub_5m7_cout", 32'(cout), 32'd0);
        release_result();
        do_op(8'h07, 8'h05, 1'b0, lat);
        check("sub_7m5_sum", 32'(sum), 32'h02);
        check("sub_7m5_cout", 32'(cout), 32'd1);
        release_result();
        op_sub = 1'b0;
`endif

        // Back-to-back with in_valid and out_ready held high: each accept
        // is followed by WIDTH+2 busy cycles before in_ready returns
        a            = 8'h01;
        b            = 8'h02;
        cin          = 1'b0;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        n_acc        = 0;
        busy         = 0;
        gaps_checked = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                if (n_acc > 0 && gaps_checked < 3) begin
                    check("b2b_gap", 32'(busy), 32'(WIDTH + 2));
                    gaps_checked++;
                end
                n_acc++;
                busy = 0;
            end else begin
                busy++;
            end
            if (out_valid) check("b2b_sum", {23'd0, cout, sum}, 32'h003);
            @(posedge clk);
            #1;
        end
        check("b2b_gap_count", 32'(gaps_checked), 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
